// File: rtl/wave_classifier_if.sv
// Sample stream into the classifier plus its classification results.
// WAVE_CLS_MINMAX_EN adds the per-period wave_min/wave_max results.
interface wave_classifier_if #(
  parameter int unsigned W     = 5,
  parameter int unsigned CNT_W = 8
);
  logic [W-1:0]     wave_in;
  logic             wave_vld;
  logic [1:0]       wave_type;
  logic             locked;
  logic [CNT_W-1:0] period;
  logic             period_vld;
  logic             mismatch;
`ifdef WAVE_CLS_MINMAX_EN
  logic [W-1:0]     wave_min;
  logic [W-1:0]     wave_max;

  modport master (
    output wave_in, wave_vld,
    input  wave_type, locked, period, period_vld, mismatch, wave_min, wave_max
  );
  modport slave (
    input  wave_in, wave_vld,
    output wave_type, locked, period, period_vld, mismatch, wave_min, wave_max
  );
`else
  modport master (
    output wave_in, wave_vld,
    input  wave_type, locked, period, period_vld, mismatch
  );
  modport slave (
    input  wave_in, wave_vld,
    output wave_type, locked, period, period_vld, mismatch
  );
`endif
endinterface

// File: rtl/wave_classifier.sv
// Identifies square/sawtooth/triangle from the step pattern, measures its period and flags deviations.
// Optional WAVE_CLS_MINMAX_EN: per-period sample extrema on wave_min/wave_max.
module wave_classifier #(
  parameter int unsigned W     = 5,
  parameter int unsigned CNT_W = 8
) (
  input logic              clk,
  input logic              rst,
  wave_classifier_if.slave bus
);
  localparam logic [W-1:0]     MAX     = {W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {S_EMPTY, S_HUNT, S_ANCH1, S_LOCK} state_e;
  typedef enum logic [2:0] {ST_HOLD, ST_UP1, ST_DN1, ST_JUP, ST_JDN, ST_OTHER} step_e;

  state_e           state_q, state_d;
  logic [W-1:0]     prev_q, prev_d;
  logic [2:0]       mask_q, mask_d;
  logic             dir_up_q, dir_up_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             locked_q, locked_d;
  logic [1:0]       type_q, type_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             period_vld_q, period_vld_d;
  logic             mismatch_q, mismatch_d;
`ifdef WAVE_CLS_MINMAX_EN
  logic [W-1:0]     rmin_q, rmin_d, rmax_q, rmax_d;
  logic [W-1:0]     wmin_q, wmin_d, wmax_q, wmax_d;
`endif

  logic [W-1:0]     cur;
  logic [W:0]       cur_x, prev_x;
  step_e            step;
  logic [2:0]       allow, mask_new;
  logic             anchor, restart;
  logic [1:0]       type_enc;
  logic [CNT_W-1:0] cnt_inc;

  assign cur = bus.wave_in;

  // Step class and the candidate set it permits; {tri, saw, sq}
  always_comb begin
    cur_x  = {1'b0, cur};
    prev_x = {1'b0, prev_q};
    step   = ST_OTHER;
    if (cur == prev_q)                     step = ST_HOLD;
    else if (prev_q == '0 && cur == MAX)   step = ST_JUP;
    else if (prev_q == MAX && cur == '0)   step = ST_JDN;
    else if (cur_x == prev_x + (W+1)'(1))  step = ST_UP1;
    else if (prev_x == cur_x + (W+1)'(1))  step = ST_DN1;

    allow = 3'b000;
    unique case (step)
      ST_HOLD: allow = (cur == '0 || cur == MAX) ? 3'b001 : 3'b000;
      ST_JUP:  allow = 3'b001;
      ST_JDN:  allow = 3'b011;
      ST_UP1:  allow = (dir_up_q || prev_q == '0) ? 3'b110 : 3'b010;
      ST_DN1:  allow = (!dir_up_q || prev_q == MAX) ? 3'b100 : 3'b000;
      default: allow = 3'b000;
    endcase
  end

  // Next state: mask narrowing, anchors, period measurement, lock/mismatch
  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    mask_d       = mask_q;
    dir_up_d     = dir_up_q;
    cnt_d        = cnt_q;
    locked_d     = locked_q;
    type_d       = type_q;
    period_d     = period_q;
    period_vld_d = 1'b0;
    mismatch_d   = 1'b0;
    restart      = 1'b0;
`ifdef WAVE_CLS_MINMAX_EN
    rmin_d = rmin_q;
    rmax_d = rmax_q;
    wmin_d = wmin_q;
    wmax_d = wmax_q;
`endif

    mask_new = mask_q & allow;
    anchor   = $onehot(mask_new) &&
               ((mask_new[0] && step == ST_JUP) ||
                (mask_new[1] && step == ST_JDN) ||
                (mask_new[2] && step == ST_UP1 && prev_q == '0));
    type_enc = mask_new[2] ? 2'd2 : (mask_new[1] ? 2'd1 : 2'd0);
    cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    if (bus.wave_vld) begin
      prev_d = cur;
      if (state_q == S_EMPTY) begin
        state_d = S_HUNT;
      end else begin
        if (step == ST_UP1)      dir_up_d = 1'b1;
        else if (step == ST_DN1) dir_up_d = 1'b0;

        if (mask_new == '0) begin
          // Failing step is dropped; the current sample seeds the fresh search
          restart = 1'b1;
          state_d = S_HUNT;
          mask_d  = 3'b111;
          cnt_d   = '0;
          if (state_q == S_LOCK) begin
            mismatch_d = 1'b1;
            locked_d   = 1'b0;
            type_d     = 2'd3;
          end
        end else begin
          mask_d = mask_new;
          cnt_d  = anchor ? CNT_W'(1) : cnt_inc;
          if (anchor) begin
            if (state_q == S_HUNT) begin
              state_d = S_ANCH1;
            end else begin
              state_d      = S_LOCK;
              locked_d     = 1'b1;
              type_d       = type_enc;
              period_d     = cnt_q;
              period_vld_d = 1'b1;
            end
          end
        end
      end
`ifdef WAVE_CLS_MINMAX_EN
      if (state_q == S_EMPTY || restart || anchor) begin
        rmin_d = cur;
        rmax_d = cur;
      end else begin
        rmin_d = (cur < rmin_q) ? cur : rmin_q;
        rmax_d = (cur > rmax_q) ? cur : rmax_q;
      end
      if (period_vld_d) begin
        wmin_d = rmin_q;
        wmax_d = rmax_q;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_EMPTY;
      prev_q       <= '0;
      mask_q       <= 3'b111;
      dir_up_q     <= 1'b1;
      cnt_q        <= '0;
      locked_q     <= 1'b0;
      type_q       <= 2'd3;
      period_q     <= '0;
      period_vld_q <= 1'b0;
      mismatch_q   <= 1'b0;
`ifdef WAVE_CLS_MINMAX_EN
      rmin_q <= '0;
      rmax_q <= '0;
      wmin_q <= '0;
      wmax_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      mask_q       <= mask_d;
      dir_up_q     <= dir_up_d;
      cnt_q        <= cnt_d;
      locked_q     <= locked_d;
      type_q       <= type_d;
      period_q     <= period_d;
      period_vld_q <= period_vld_d;
      mismatch_q   <= mismatch_d;
`ifdef WAVE_CLS_MINMAX_EN
      rmin_q <= rmin_d;
      rmax_q <= rmax_d;
      wmin_q <= wmin_d;
      wmax_q <= wmax_d;
`endif
    end
  end

  assign bus.wave_type  = type_q;
  assign bus.locked     = locked_q;
  assign bus.period     = period_q;
  assign bus.period_vld = period_vld_q;
  assign bus.mismatch   = mismatch_q;
`ifdef WAVE_CLS_MINMAX_EN
  assign bus.wave_min   = wmin_q;
  assign bus.wave_max   = wmax_q;
`endif
endmodule

// File: tb/tb_wave_classifier.sv
// Scoreboard bench for wave_classifier: directed waveforms, expected period/mismatch events queued ahead.
module tb_wave_classifier;
  localparam int unsigned W     = 5;
  localparam int unsigned CNT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wave_classifier_if #(.W(W), .CNT_W(CNT_W)) bus ();
  wave_classifier #(.W(W), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    bit mm;
    int typ;
    bit lk;
    int per;
    int idx;
    int mn;
    int mx;
  } ev_t;

  ev_t exp_q[$];
  int  n_vec  = 0;
  int  n_miss = 0;
  int  acc_n  = 0;
  bit  last_vld = 1'b0;
  bit  chk_frozen = 1'b0;
  int  snap_lk, snap_ty, snap_per;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_pv(input int typ, input int per, input int idx, input int mn, input int mx);
    ev_t e;
    e = '{mm: 1'b0, typ: typ, lk: 1'b1, per: per, idx: idx, mn: mn, mx: mx};
    exp_q.push_back(e);
  endtask

  task automatic push_mm(input int per, input int idx);
    ev_t e;
    e = '{mm: 1'b1, typ: 3, lk: 1'b0, per: per, idx: idx, mn: 0, mx: 0};
    exp_q.push_back(e);
  endtask

  // Monitor: pop one expected event for every pulse the DUT presents
  always @(negedge clk) begin
    if (!rst && (bus.period_vld || bus.mismatch)) begin
      ev_t e;
      chk("pulse_excl", int'(bus.period_vld && bus.mismatch), 0);
      chk("sb_pending", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("ev_kind",   int'(bus.mismatch),  int'(e.mm));
        chk("ev_type",   int'(bus.wave_type), e.typ);
        chk("ev_locked", int'(bus.locked),    int'(e.lk));
        chk("ev_period", int'(bus.period),    e.per);
        chk("ev_index",  acc_n,               e.idx);
`ifdef WAVE_CLS_MINMAX_EN
        if (!e.mm) begin
          chk("ev_min", int'(bus.wave_min), e.mn);
          chk("ev_max", int'(bus.wave_max), e.mx);
        end
`endif
      end
    end
    if (!rst && chk_frozen && !last_vld) begin
      chk("frz_pv",     int'(bus.period_vld), 0);
      chk("frz_mm",     int'(bus.mismatch),   0);
      chk("frz_locked", int'(bus.locked),     snap_lk);
      chk("frz_type",   int'(bus.wave_type),  snap_ty);
      chk("frz_period", int'(bus.period),     snap_per);
    end
    snap_lk  = int'(bus.locked);
    snap_ty  = int'(bus.wave_type);
    snap_per = int'(bus.period);
  end

  task automatic send(input int v, input bit vld);
    bus.wave_in  = 5'(v);
    bus.wave_vld = vld;
    @(posedge clk);
    #1;
    if (vld && !rst) acc_n++;
    last_vld = vld;
  endtask

  task automatic send_sq(input int from, input int to);
    for (int i = from; i < to; i++) send(((i % 32) < 16) ? 0 : 31, 1'b1);
  endtask

  task automatic send_saw(input int from, input int to, input bit gap);
    for (int i = from; i < to; i++) begin
      send(i % 32, 1'b1);
      if (gap) send(int'($urandom_range(0, 31)), 1'b0);
    end
  endtask

  task automatic send_tri(input int from, input int to);
    for (int i = from; i < to; i++) begin
      int p;
      p = i % 62;
      send((p <= 31) ? p : 62 - p, 1'b1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.wave_vld = 1'b1;
    bus.wave_in  = 5'd5;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.wave_vld = 1'b0;
    acc_n = 0;
    chk("rst_type",   int'(bus.wave_type),  3);
    chk("rst_locked", int'(bus.locked),     0);
    chk("rst_period", int'(bus.period),     0);
    chk("rst_pv",     int'(bus.period_vld), 0);
    chk("rst_mm",     int'(bus.mismatch),   0);
  endtask

  task automatic drain(input string nm);
    @(negedge clk);
    #1;
    chk(nm, int'(exp_q.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wave_vld = 1'b0;
    bus.wave_in  = '0;
    repeat (2) @(posedge clk);
    #1;

    // Square 16x0 / 16x31: anchors at samples 17, 49, 81, 113
    do_reset();
    push_pv(0, 32, 49, 0, 31);
    push_pv(0, 32, 81, 0, 31);
    push_pv(0, 32, 113, 0, 31);
    send_sq(0, 48);
    chk("sq_prelock", int'(bus.locked), 0);
    send_sq(48, 49);
    chk("sq_lock",   int'(bus.locked),    1);
    chk("sq_type",   int'(bus.wave_type), 0);
    chk("sq_period", int'(bus.period),    32);
    send_sq(49, 128);
    drain("sq_drain");

    // Sawtooth 0..31: anchors on 31->0 at samples 33, 65, 97
    do_reset();
    push_pv(1, 32, 65, 0, 31);
    push_pv(1, 32, 97, 0, 31);
    send_saw(0, 64, 1'b0);
    chk("saw_prelock", int'(bus.locked), 0);
    send_saw(64, 65, 1'b0);
    chk("saw_lock", int'(bus.locked),    1);
    chk("saw_type", int'(bus.wave_type), 1);
    send_saw(65, 128, 1'b0);
    drain("saw_drain");

    // Triangle 0..31..1: tri one-hot at 31->30, anchors at samples 64, 126, 188
    do_reset();
    push_pv(2, 62, 126, 0, 31);
    push_pv(2, 62, 188, 0, 31);
    send_tri(0, 200);
    chk("tri_lock",   int'(bus.locked),    1);
    chk("tri_type",   int'(bus.wave_type), 2);
    chk("tri_period", int'(bus.period),    62);
    drain("tri_drain");

    // Switch to square mid up-ramp (last sample 13): mismatch, then re-lock
    acc_n = 0;
    push_mm(62, 1);
    push_pv(0, 32, 49, 0, 31);
    push_pv(0, 32, 81, 0, 31);
    send_sq(0, 1);
    chk("sw_unlock", int'(bus.locked),    0);
    chk("sw_type",   int'(bus.wave_type), 3);
    chk("sw_period", int'(bus.period),    62);
    send_sq(1, 96);
    chk("sw_relock", int'(bus.locked),    1);
    chk("sw_retype", int'(bus.wave_type), 0);
    drain("sw_drain");

    // Sawtooth with an invalid cycle after every sample
    do_reset();
    push_pv(1, 32, 65, 0, 31);
    push_pv(1, 32, 97, 0, 31);
    chk_frozen = 1'b1;
    send_saw(0, 128, 1'b1);
    chk_frozen = 1'b0;
    chk("gap_lock",   int'(bus.locked), 1);
    chk("gap_period", int'(bus.period), 32);
    drain("gap_drain");

    // One-cycle reset while locked (with wave_vld high), then re-lock as square
    do_reset();
    push_pv(0, 32, 49, 0, 31);
    push_pv(0, 32, 81, 0, 31);
    send_sq(0, 48);
    chk("rr_prelock", int'(bus.locked), 0);
    send_sq(48, 96);
    chk("rr_lock", int'(bus.locked), 1);
    drain("rr_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/wave_classifier.md
# wave_classifier

Downstream monitor stage for the 5-bit waveform generator. Consumes the generator's `wave` sample stream and identifies the waveform as square, sawtooth or triangular from its step pattern. Once identified, it measures the period in samples and flags any later deviation. Used in self-checking benches and as an on-chip health monitor behind the generator.

## Interface
- `W`, 5: sample width; full scale `MAX = 2**W-1`
- `CNT_W`, 8: period counter / output width
- `clk` in 1: clock, all logic on rising edge
- `rst` in 1: synchronous, active-high reset
- `wave_in` in W: sample from generator
- `wave_vld` in 1: sample strobe; a sample is accepted only when high
- `wave_type` out 2: 0 square, 1 sawtooth, 2 triangular, 3 unknown
- `locked` out 1: `wave_type` and `period` are valid
- `period` out CNT_W: last measured period in samples
- `period_vld` out 1: one-cycle pulse when `period` updates
- `mismatch` out 1: one-cycle pulse when a locked stream violates its type

## Operation
- Every accepted sample after the first forms a step `(prev, cur)`. The first sample after reset or restart is stored only.
- Step classes:
  - HOLD: `cur==prev`
  - UP1: `cur==prev+1`
  - DN1: `cur==prev-1`
  - JUP: `prev==0, cur==MAX`
  - JDN: `prev==MAX, cur==0`
  - OTHER: anything else
- 3-bit candidate mask {tri, saw, sq}, set to 111 on reset or restart. Each step ANDs the mask with the allowed set:
  - HOLD: sq, only if `cur` is 0 or MAX; otherwise none
  - JUP: sq
  - JDN: sq and saw
  - UP1: saw, plus tri unless the direction flag says down and `prev!=0`
  - DN1: tri, only if the flag says up and `prev==MAX`, or the flag says down
  - OTHER: none
- Triangle direction flag: set up on UP1, down on DN1.
- Mask result zero while unlocked:
  - Restart. Mask becomes 111, `cur` becomes `prev`, anchors and counter are cleared.
  - The failing step is discarded. No `mismatch` pulse.
- Anchor steps count only while the mask is one-hot, evaluated after the AND:
  - sq: JUP
  - saw: JDN
  - tri: UP1 with `prev==0`
- Period counter:
  - At an anchor, the counter is loaded with 1. Otherwise it increments per accepted sample and saturates at `2**CNT_W-1`.
  - At each anchor after the first, `period` takes the counter value and `period_vld` pulses.
  - At the second anchor, `locked` sets and `wave_type` takes the one-hot candidate's encoding.
- While locked, a step outside the locked type's allowed set:
  - `mismatch` pulses; `locked` clears; `wave_type` goes to 3.
  - Restart as above, with `cur` kept as `prev`.
  - `period` holds its last value.
- `wave_vld` low: nothing changes; pulse outputs are low.

## Timing
- All outputs are registered and update on the edge that accepts the triggering sample, so they are visible in the following cycle.
- Reset values: `wave_type`=3, `locked`=0, `period`=0, `period_vld`=0, `mismatch`=0. Mask is 111, no stored sample.
- `rst` wins over a coincident `wave_vld`.
- Reset mid-lock discards all state; re-lock needs two fresh anchors.
- Back-to-back valid samples are supported at one per cycle with no stall.
- `period_vld` and `mismatch` never assert in the same cycle.
- Re-lock after a generator switch: the new type locks on its second anchor, with no added latency.

## Configuration
- `WAVE_CLS_MINMAX_EN` defined: adds outputs `wave_min` (W) and `wave_max` (W).
  - Tracks the extrema of samples accepted since the previous anchor.
  - Both are registered at each `period_vld` and reset to 0.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

## Test plan
- Square, 16 samples of 0 then 16 of 31, repeated, `wave_vld` always high:
  - lock after the second 0→31 step
  - `wave_type`=0, `period`=32
  - `period_vld` every 32 samples thereafter
  - with macro: `wave_min`=0, `wave_max`=31
- Sawtooth 0..31 repeated:
  - `wave_type`=1, `period`=32, locked on the second 31→0 step
- Triangle 0..31..1 repeated:
  - `wave_type`=2, `period`=62
  - no `mismatch` at either turnaround
- Triangle locked, then switch to square mid-ramp:
  - `mismatch` pulses once; `locked` drops; `wave_type`=3
  - re-lock as square with `period`=32 after two anchors
- Sawtooth with `wave_vld` low every other cycle:
  - same `period`=32; outputs frozen in invalid cycles
- Assert `rst` for one cycle while locked:
  - next cycle `locked`=0, `wave_type`=3, `period`=0
  - re-lock as in the first scenario
